// File: rtl/audio_mixer_pkg.sv
// Shared types and helpers for the audio mixer: FSM states, volume/pan layout
// and the output saturation function.
package audio_mixer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_CLIP  = 2'd2
    } state_t;

    localparam int VOL_W = 4;
    localparam int PAN_L = 0;
    localparam int PAN_R = 1;

    // Clamp a wide signed value into the range of an sw-bit signed sample.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned     sw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (sw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (sw - 1));
        if (v > hi)
            saturate = hi;
        else if (v < lo)
            saturate = lo;
        else
            saturate = v;
    endfunction

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta modulator: the signed sample is shifted to offset
// binary and integrated; the carry out of the integrator is the bitstream.
module sigma_delta_dac #(
    parameter int SW = 16
) (
    input  logic          F14M,
    input  logic          RESET,
    input  logic [SW-1:0] din,
    output logic          dout
);

    logic [SW:0]   acc_q;
    logic [SW:0]   acc_d;
    logic [SW-1:0] u;

    always_comb begin
        u     = din ^ {1'b1, {(SW-1){1'b0}}};
        acc_d = {1'b0, acc_q[SW-1:0]} + {1'b0, u};
    end

    always_ff @(posedge F14M) begin
        if (RESET)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign dout = acc_q[SW];

endmodule

// File: rtl/audio_mixer_sd.sv
// Multi-channel stereo mixer: one channel is multiply-accumulated per cycle,
// the sums are clipped to the sample range and fed to two sigma-delta DACs.
module audio_mixer_sd
    import audio_mixer_pkg::*;
#(
    parameter int NCH = 4,
    parameter int SW  = 16
) (
    input  logic                 F14M,
    input  logic                 RESET,
    input  logic                 sample_stb,
    input  logic [NCH*SW-1:0]    ch_data,
    input  logic [NCH*VOL_W-1:0] ch_vol,
    input  logic [NCH*2-1:0]     ch_pan,
    input  logic                 mute,
    output logic [SW-1:0]        mix_l,
    output logic [SW-1:0]        mix_r,
    output logic                 mix_valid,
    output logic                 overrun,
    output logic                 dac_l,
    output logic                 dac_r
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    // Worst case |sample*15| summed over every channel still fits with a spare bit.
    localparam int AW = SW + VOL_W + $clog2(NCH) + 1;

    state_t                     state_q, state_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [NCH*SW-1:0]          data_q, data_d;
    logic [NCH*VOL_W-1:0]       vol_q, vol_d;
    logic [NCH*2-1:0]           pan_q, pan_d;
    logic signed [AW-1:0]       acc_l_q, acc_l_d;
    logic signed [AW-1:0]       acc_r_q, acc_r_d;
    logic [SW-1:0]              mix_l_q, mix_l_d;
    logic [SW-1:0]              mix_r_q, mix_r_d;
    logic                       valid_q, valid_d;
    logic                       ovr_q, ovr_d;
    logic [SW-1:0]              sd_din_l_q, sd_din_l_d;
    logic [SW-1:0]              sd_din_r_q, sd_din_r_d;

    logic signed [SW-1:0]       sel_smp;
    logic [VOL_W-1:0]           sel_vol;
    logic [1:0]                 sel_pan;
    logic signed [AW-1:0]       smp_ext;
    logic signed [AW-1:0]       vol_ext;
    logic signed [AW-1:0]       prod;
    logic [SW-1:0]              sat_l;
    logic [SW-1:0]              sat_r;

    always_comb begin
        sel_smp = data_q[int'(idx_q)*SW +: SW];
        sel_vol = vol_q[int'(idx_q)*VOL_W +: VOL_W];
        sel_pan = pan_q[int'(idx_q)*2 +: 2];
        smp_ext = AW'(sel_smp);
        vol_ext = AW'({1'b0, sel_vol});
        prod    = smp_ext * vol_ext;
        sat_l   = SW'(saturate(64'(acc_l_q >>> VOL_W), SW));
        sat_r   = SW'(saturate(64'(acc_r_q >>> VOL_W), SW));
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        data_d     = data_q;
        vol_d      = vol_q;
        pan_d      = pan_q;
        acc_l_d    = acc_l_q;
        acc_r_d    = acc_r_q;
        mix_l_d    = mix_l_q;
        mix_r_d    = mix_r_q;
        valid_d    = 1'b0;
        ovr_d      = ovr_q;
        sd_din_l_d = sd_din_l_q;
        sd_din_r_d = sd_din_r_q;

        case (state_q)
            S_IDLE: begin
                if (sample_stb) begin
                    data_d  = ch_data;
                    vol_d   = ch_vol;
                    pan_d   = ch_pan;
                    acc_l_d = '0;
                    acc_r_d = '0;
                    idx_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (sel_pan[PAN_L])
                    acc_l_d = acc_l_q + prod;
                if (sel_pan[PAN_R])
                    acc_r_d = acc_r_q + prod;
                if (idx_q == IW'(NCH - 1)) begin
                    idx_d   = '0;
                    state_d = S_CLIP;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
                if (sample_stb)
                    ovr_d = 1'b1;
            end
            S_CLIP: begin
                mix_l_d    = sat_l;
                mix_r_d    = sat_r;
                valid_d    = 1'b1;
                // Mute only silences the DACs; the mixed samples still publish.
                sd_din_l_d = mute ? '0 : sat_l;
                sd_din_r_d = mute ? '0 : sat_r;
                state_d    = S_IDLE;
                if (sample_stb)
                    ovr_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge F14M) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            data_q     <= '0;
            vol_q      <= '0;
            pan_q      <= '0;
            acc_l_q    <= '0;
            acc_r_q    <= '0;
            mix_l_q    <= '0;
            mix_r_q    <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
            sd_din_l_q <= '0;
            sd_din_r_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            vol_q      <= vol_d;
            pan_q      <= pan_d;
            acc_l_q    <= acc_l_d;
            acc_r_q    <= acc_r_d;
            mix_l_q    <= mix_l_d;
            mix_r_q    <= mix_r_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
            sd_din_l_q <= sd_din_l_d;
            sd_din_r_q <= sd_din_r_d;
        end
    end

    sigma_delta_dac #(.SW(SW)) u_sd_l (
        .F14M  (F14M),
        .RESET (RESET),
        .din   (sd_din_l_q),
        .dout  (dac_l)
    );

    sigma_delta_dac #(.SW(SW)) u_sd_r (
        .F14M  (F14M),
        .RESET (RESET),
        .din   (sd_din_r_q),
        .dout  (dac_r)
    );

    assign mix_l     = mix_l_q;
    assign mix_r     = mix_r_q;
    assign mix_valid = valid_q;
    assign overrun   = ovr_q;

endmodule

// File: doc/audio_mixer_sd.md
AUDIO_MIXER_SD -- requirements
Module: audio_mixer_sd

Interface
REQ-001 Parameter NCH, default 4: number of mixer channels, minimum 1.
REQ-002 Parameter SW, default 16: signed sample width, used for inputs and mixed outputs.
REQ-003 Port F14M, input, 1 bit: system clock; all logic is rising-edge.
REQ-004 Port RESET, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port sample_stb, input, 1 bit: one-cycle request to mix the current inputs.
REQ-006 Port ch_data, input, NCH*SW bits: packed signed samples, channel 0 in the LSBs.
REQ-007 Port ch_vol, input, NCH*4 bits: per-channel volume 0..15, applied as gain vol/16.
REQ-008 Port ch_pan, input, NCH*2 bits: per-channel enables {R,L}; bit0 routes the channel to left, bit1 to right.
REQ-009 Port mute, input, 1 bit: global mute.
REQ-010 Ports mix_l and mix_r, output, SW bits each: registered signed mixed samples.
REQ-011 Port mix_valid, output, 1 bit: one-cycle pulse that marks a mix_l/mix_r update.
REQ-012 Port overrun, output, 1 bit: sticky flag for a dropped strobe.
REQ-013 Ports dac_l and dac_r, output, 1 bit each: first-order sigma-delta bitstreams.

Function
REQ-014 The FSM SHALL have three states: IDLE, ACCUM and CLIP.
REQ-015 In IDLE, sample_stb SHALL latch ch_data, ch_vol and ch_pan, clear both accumulators, set channel index 0, and move to ACCUM.
REQ-016 In ACCUM, each cycle SHALL add sample[idx]*vol[idx] to the L accumulator if pan bit0 is set, and to the R accumulator if pan bit1 is set.
REQ-017 ACCUM SHALL increment idx each cycle and move to CLIP after idx = NCH-1, so ACCUM lasts exactly NCH cycles.
REQ-018 Accumulator width SHALL be SW+4+clog2(NCH)+1 bits, signed, and SHALL never overflow.
REQ-019 In CLIP, each accumulator SHALL be arithmetic-shifted right by 4, then saturated to [-2^(SW-1), 2^(SW-1)-1].
REQ-020 CLIP SHALL register the results into mix_l and mix_r, pulse mix_valid at the next edge, and return to IDLE.
REQ-021 mix_valid SHALL assert exactly NCH+2 cycles after the cycle in which the strobe was sampled.
REQ-022 A strobe in the cycle mix_valid is high SHALL be accepted.
REQ-023 A sample_stb seen in ACCUM or CLIP SHALL be ignored and SHALL set overrun to 1.
REQ-024 The in-progress mix SHALL complete unaffected by an ignored strobe.
REQ-025 When mute=1, the sigma-delta inputs SHALL be 0; mix_l and mix_r still update.
REQ-026 The sigma-delta modulators SHALL run every clock.
REQ-027 Sigma-delta operation: u = mix XOR 2^(SW-1) (offset binary); acc[SW:0] <= acc[SW-1:0] + u; dac = acc[SW].
REQ-028 The sigma-delta input SHALL change only on mix_valid cycles.
REQ-029 Channels with vol=0 SHALL contribute 0 while still consuming their ACCUM cycle.

Reset
REQ-030 RESET SHALL force the state to IDLE and idx to 0.
REQ-031 RESET SHALL clear accumulators, mix_l, mix_r, mix_valid, overrun, sigma-delta accumulators, dac_l and dac_r.
REQ-032 RESET SHALL take priority over sample_stb.
REQ-033 RESET during ACCUM or CLIP SHALL abort the mix; no mix_valid pulse follows.
REQ-034 overrun SHALL be cleared only by RESET.

Structure
REQ-035 Shared package audio_mixer_pkg SHALL hold the state enum, VOL_W=4, the PAN_L=0 and PAN_R=1 bit indices, and the saturate function.
REQ-036 Sub-module sigma_delta_dac (parameter SW; ports F14M, RESET, din, dout) SHALL be instantiated twice, once for L and once for R.

Verification (NCH=4, SW=16)
REQ-037 Single channel: ch0=0x4000, vol0=15, pan0=L, other vols 0; strobe at cycle 0 -> mix_valid in cycle 6, mix_l=0x3C00, mix_r=0x0000.
REQ-038 Saturation, positive: all channels 0x7FFF, vol 15, pan both -> mix_l=mix_r=0x7FFF.
REQ-039 Saturation, negative: all channels 0x8000, vol 15, pan both -> mix_l=mix_r=0x8000.
REQ-040 Overrun: second strobe at cycle 3 -> ignored, overrun=1 and stays 1, a single mix_valid in cycle 6 with the first result.
REQ-041 Strobe in the mix_valid cycle -> accepted, second mix_valid exactly 6 cycles later.
REQ-042 Bitstream density: mix_l=0x3C00 held for 65536 cycles after reset -> exactly 48128 ones on dac_l.
REQ-043 Mute: mute=1 -> dac_l alternates 0,1 and gives 512 ones per 1024 cycles.
REQ-044 Reset mid-mix: RESET in cycle 2 of ACCUM -> next cycle state IDLE, all outputs 0, no mix_valid, overrun 0.
